// File: rtl/instr_mem_loader_pkg.sv
// Shared loader definitions: FSM state encoding,
// header width and byte-lane count.
package instr_mem_loader_pkg;

   localparam int HDR_W  = 16;
   localparam int LANES  = 4;
   localparam int LANE_W = $clog2(LANES);

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA,
      WRITE,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/instr_mem_loader_byte_to_word.sv
// Assembles little-endian bytes into a 32-bit word.
// Ports: clk, rst (async low), clr, shift, byte_data -> word, lane, last.
module byte_to_word
   import instr_mem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              shift,
   input  logic [7:0]        byte_data,
   output logic [31:0]       word,
   output logic [LANE_W-1:0] lane,
   output logic              last
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word <= '0;
         lane <= '0;
      end else if (clr) begin
         lane <= '0;
      end else if (shift) begin
         // Shift right so the first byte ends in [7:0].
         word <= {byte_data, word[31:8]};
         lane <= lane + LANE_W'(1);
      end
   end

   assign last = (lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream instruction memory loader; holds the core in reset until done.
// Ports: byte handshake in, load_req, memory write port, cpu_rst/done/err.
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic              load_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   localparam logic [HDR_W:0] DEPTH_W = (HDR_W + 1)'(DEPTH);

   state_t             state;
   state_t             state_n;
   logic               live;
   logic [7:0]         hdr_lo;
   logic [HDR_W-1:0]   remaining;
   logic [ADDR_W-1:0]  addr;
   logic [HDR_W-1:0]   n;
   logic               too_big;
   logic               xfer;
   logic               clr;
   logic               shift;
   logic               last;
   logic [LANE_W-1:0]  lane;

   // live keeps byte_ready low until the first edge after reset.
   assign byte_ready = live &&
      (state == HDR_LO || state == HDR_HI || state == DATA);
   assign xfer    = byte_valid && byte_ready;
   assign n       = {byte_data, hdr_lo};
   assign too_big = {1'b0, n} > DEPTH_W;

   assign mem_we   = (state == WRITE);
   assign mem_addr = addr;
   assign cpu_rst  = (state == DONE);
   assign done     = (state == DONE);
   assign err      = (state == ERR);

   byte_to_word u_b2w (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .shift     (shift),
      .byte_data (byte_data),
      .word      (mem_wdata),
      .lane      (lane),
      .last      (last)
   );

   always_comb begin
      state_n = state;
      clr     = 1'b0;
      shift   = 1'b0;
      unique case (state)
         HDR_LO: if (xfer) state_n = HDR_HI;
         HDR_HI: begin
            if (xfer) begin
               if (n == '0) begin
                  state_n = DONE;
               end else if (too_big) begin
                  state_n = ERR;
               end else begin
                  state_n = DATA;
                  clr     = 1'b1;
               end
            end
         end
         DATA: begin
            if (xfer) begin
               shift = 1'b1;
               if (last) state_n = WRITE;
            end
         end
         WRITE: begin
            if (remaining == HDR_W'(1)) begin
               state_n = DONE;
            end else begin
               state_n = DATA;
               clr     = 1'b1;
            end
         end
         DONE, ERR: if (load_req) state_n = HDR_LO;
         default: state_n = HDR_LO;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= HDR_LO;
         live      <= 1'b0;
         hdr_lo    <= '0;
         remaining <= '0;
         addr      <= '0;
      end else begin
         state <= state_n;
         live  <= 1'b1;
         if (state == HDR_LO && xfer) hdr_lo <= byte_data;
         if (state == HDR_HI && xfer) begin
            remaining <= n;
            addr      <= '0;
         end
         if (state == WRITE) begin
            remaining <= remaining - HDR_W'(1);
            addr      <= addr + ADDR_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader.
// Expected writes are queued at stimulus time and popped on each mem_we.
module tb_instr_mem_loader;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              byte_valid = 1'b0;
   logic [7:0]        byte_data = '0;
   logic              byte_ready;
   logic              load_req = 1'b0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_rst;
   logic              done;
   logic              err;

   int tests = 0;
   int fails = 0;
   int wr_cnt = 0;

   logic [ADDR_W-1:0] exp_addr[$];
   logic [31:0]       exp_data[$];

   instr_mem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .load_req   (load_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_rst    (cpu_rst),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Write monitor / scoreboard.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_cnt++;
         tests++;
         if (exp_addr.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write addr=%0h data=%08h", mem_addr, mem_wdata);
         end else begin
            logic [ADDR_W-1:0] ea;
            logic [31:0] ed;
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            if (mem_addr !== ea || mem_wdata !== ed) begin
               fails++;
               $display("FAIL write got %0h/%08h want %0h/%08h", mem_addr, mem_wdata, ea, ed);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int max_gap);
      int gap;
      bit ok;
      gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
      for (int i = 0; i < gap; i++) @(negedge clk);
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = b;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (byte_ready === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      #1 byte_valid = 1'b0;
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL send_timeout byte=%02h", b);
      end
   endtask

   task automatic wait_end(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done === 1'b1 || err === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s end_timeout got 0 want 1", name);
      end
   endtask

   task automatic pulse_load();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      exp_addr.push_back(a);
      exp_data.push_back(d);
   endtask

   task automatic test_reset();
      #3;
      chk("rst_we", 32'(mem_we), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_cpu_rst", 32'(cpu_rst), 0);
      chk("rst_ready", 32'(byte_ready), 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(byte_ready), 1);
   endtask

   task automatic test_two_words();
      logic [7:0] s [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00,
                             8'h93, 8'h00, 8'h10, 8'h00};
      int w0;
      w0 = wr_cnt;
      push(0, 32'h00500013);
      push(1, 32'h00100093);
      foreach (s[i]) send_byte(s[i], 0);
      wait_end("two_words");
      chk("two_done", 32'(done), 1);
      chk("two_cpu_rst", 32'(cpu_rst), 1);
      chk("two_err", 32'(err), 0);
      chk("two_writes", 32'(wr_cnt - w0), 2);
      chk("two_sb_empty", 32'(exp_addr.size()), 0);
   endtask

   task automatic test_zero();
      int w0;
      w0 = wr_cnt;
      pulse_load();
      chk("reload_cpu_rst_low", 32'(cpu_rst), 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(negedge clk);
      chk("zero_cpu_rst", 32'(cpu_rst), 1);
      chk("zero_done", 32'(done), 1);
      chk("zero_writes", 32'(wr_cnt - w0), 0);
   endtask

   task automatic test_err();
      int w0;
      w0 = wr_cnt;
      pulse_load();
      send_byte(8'h01, 0);
      send_byte(8'h04, 0);
      @(negedge clk);
      chk("err_flag", 32'(err), 1);
      chk("err_cpu_rst", 32'(cpu_rst), 0);
      chk("err_ready", 32'(byte_ready), 0);
      chk("err_done", 32'(done), 0);
      repeat (3) @(negedge clk);
      chk("err_writes", 32'(wr_cnt - w0), 0);
      pulse_load();
      chk("err_exit_err", 32'(err), 0);
      chk("err_exit_ready", 32'(byte_ready), 1);
   endtask

   task automatic test_random_valid();
      logic [7:0] s [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      int w0;
      w0 = wr_cnt;
      push(0, 32'hDEADBEEF);
      foreach (s[i]) send_byte(s[i], 3);
      wait_end("rand_valid");
      chk("rand_done", 32'(done), 1);
      chk("rand_writes", 32'(wr_cnt - w0), 1);
      chk("rand_sb_empty", 32'(exp_addr.size()), 0);
   endtask

   task automatic test_reset_midload();
      logic [7:0] s [6] = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
      int w0;
      pulse_load();
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      send_byte(8'h13, 0);
      send_byte(8'h00, 0);
      w0 = wr_cnt;
      @(negedge clk);
      rst = 1'b0;
      #2;
      chk("mid_rst_addr", 32'(mem_addr), 0);
      chk("mid_rst_ready", 32'(byte_ready), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_no_write", 32'(wr_cnt - w0), 0);
      push(0, 32'h00000013);
      foreach (s[i]) send_byte(s[i], 0);
      wait_end("midload");
      chk("mid_done", 32'(done), 1);
      chk("mid_writes", 32'(wr_cnt - w0), 1);
   endtask

   task automatic test_reload();
      logic [7:0] s [6] = '{8'h01, 8'h00, 8'h11, 8'h11, 8'h11, 8'h11};
      int w0;
      w0 = wr_cnt;
      pulse_load();
      chk("reload_cpu_rst", 32'(cpu_rst), 0);
      push(0, 32'h11111111);
      for (int i = 0; i < 4; i++) send_byte(s[i], 0);
      chk("reload_mid_cpu_rst", 32'(cpu_rst), 0);
      chk("reload_mid_done", 32'(done), 0);
      for (int i = 4; i < 6; i++) send_byte(s[i], 0);
      wait_end("reload");
      chk("reload_done", 32'(done), 1);
      chk("reload_cpu_rst_hi", 32'(cpu_rst), 1);
      chk("reload_writes", 32'(wr_cnt - w0), 1);
      chk("reload_sb_empty", 32'(exp_addr.size()), 0);
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_zero();
      test_err();
      test_random_valid();
      test_reset_midload();
      test_reload();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter DEPTH, default 1024: number of 32-bit words in instruction memory.
REQ-002 Parameter ADDR_W, default 10: word-address width, equal to clog2(DEPTH).
REQ-003 Port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port byte_valid, input, 1 bit: host presents a byte on byte_data.
REQ-006 Port byte_data, input, 8 bits: host byte stream.
REQ-007 Port byte_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-008 Port load_req, input, 1 bit: single-cycle pulse that restarts a load from DONE or ERR.
REQ-009 Port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-010 Port mem_addr, output, ADDR_W bits: word address, stepping by 1 per instruction, matching PC+1 sequencing.
REQ-011 Port mem_wdata, output, 32 bits: instruction word to write.
REQ-012 Port cpu_rst, output, 1 bit: active-low reset to the processor core, held low until the load completes.
REQ-013 Port done, output, 1 bit: load completed successfully.
REQ-014 Port err, output, 1 bit: header word count exceeded DEPTH.

Function
REQ-015 A byte SHALL transfer only on a cycle where byte_valid=1 and byte_ready=1.
REQ-016 Stream format SHALL be a 16-bit word count N, sent low byte first, followed by N words of 4 bytes each, little-endian: the first byte goes to [7:0] and the fourth to [31:24].
REQ-017 FSM states SHALL be HDR_LO, HDR_HI, DATA, WRITE, DONE and ERR.
REQ-018 byte_ready SHALL be 1 in HDR_LO, HDR_HI and DATA, and 0 in WRITE, DONE and ERR.
REQ-019 Transitions:
- HDR_LO -> HDR_HI on transfer.
- HDR_HI -> DATA on transfer if 0 < N <= DEPTH.
- HDR_HI -> DONE on transfer if N = 0.
- HDR_HI -> ERR on transfer if N > DEPTH.
- DATA -> WRITE on the 4th byte transfer.
- WRITE -> DATA if words remain, else WRITE -> DONE.
- DONE or ERR -> HDR_LO when load_req=1.
REQ-020 A 2-bit byte counter SHALL select the word lane; it clears on entry to DATA and wraps 3 -> 0 on the 4th byte.
REQ-021 When the 4th byte transfers at cycle T, mem_we SHALL be 1 for exactly cycle T+1, with mem_addr and mem_wdata valid in that cycle.
REQ-022 mem_addr SHALL start at 0 for every load and increment by 1 after each write.
REQ-023 mem_addr SHALL never exceed DEPTH-1; this is guaranteed by the N <= DEPTH check.
REQ-024 mem_we SHALL be 0 in every state other than WRITE.
REQ-025 cpu_rst SHALL be 1 only in DONE; done=1 only in DONE; err=1 only in ERR.
REQ-026 On a load_req from DONE, cpu_rst SHALL fall in the cycle after load_req, re-holding the core in reset during reload.
REQ-027 load_req SHALL be ignored in HDR_LO, HDR_HI, DATA and WRITE.
REQ-028 byte_valid with byte_data held across a non-ready cycle SHALL NOT be lost; the byte is taken on the next ready cycle.
REQ-029 The word-remaining counter SHALL be 16 bits and decrement on each WRITE.
REQ-030 The last word is the write performed with remaining = 1.

Reset
REQ-031 With rst=0, asynchronously and independent of clk:
- state = HDR_LO
- all counters = 0
- mem_we = 0, mem_addr = 0, mem_wdata = 0
- done = 0, err = 0, cpu_rst = 0
REQ-032 byte_ready SHALL be 0 while rst=0.
REQ-033 byte_ready SHALL be 1 from the first clk edge after rst is released.
REQ-034 Reset asserted mid-load SHALL abandon the load; no further mem_we pulses occur, and the next load restarts from the header.

Structure
REQ-035 FSM state encoding, the header width (16) and the byte-lane count (4) SHALL live in the shared processor package.
REQ-036 A single sub-module, byte_to_word, SHALL hold the 32-bit shift/assembly register and the 2-bit lane counter; the FSM, address counter and remaining counter live in the top.

Verification
REQ-037 Header 02 00, then 13 00 50 00, 93 00 10 00 -> mem_we pulses twice: addr0 = 0x00500013, addr1 = 0x00100093; then done=1 and cpu_rst=1.
REQ-038 Header 00 00 -> DONE reached with zero mem_we pulses; cpu_rst=1 on the cycle after the HDR_HI transfer.
REQ-039 Header 01 04 (N = 1025, DEPTH = 1024) -> err=1, no mem_we, cpu_rst stays 0; a subsequent load_req returns the FSM to HDR_LO.
REQ-040 byte_valid toggled randomly with one word EF BE AD DE -> a single write of 0xDEADBEEF at addr 0; no byte is dropped or duplicated.
REQ-041 rst pulled low after 2 bytes of a word, then a full load of N = 1 word 0x00000013 -> the write lands at addr 0 with the value 0x00000013.
REQ-042 After a DONE, load_req then a load of N = 1 word 0x11111111 -> cpu_rst low during the reload, the write lands at addr 0, then done=1 again.
